trigger_delay_meter: RTL and testbench
======================================

TRIGGER_DELAY_METER -- requirements
Module: trigger_delay_meter

Interface
REQ-001 Parameter CNT_W, default 8, width of delay counter and result.
REQ-002 Parameter TIMEOUT, default 255, max cycles waited for trigger; legal range 1..2^CNT_W-1.
REQ-003 Parameter EXPECT_DLY, default 5, nominal enable-to-trigger delay in clk cycles.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  arm request; rising edge starts a measurement.
REQ-007 trigger  input  1  response from the delayed-trigger generator; rising edge ends a measurement.
REQ-008 busy  output  1  high while waiting for trigger.
REQ-009 meas_valid  output  1  one-cycle pulse; meas_dly and meas_ok valid.
REQ-010 meas_dly  output  CNT_W  measured delay in clk cycles, held until next result.
REQ-011 meas_ok  output  1  meas_dly == EXPECT_DLY, qualified by meas_valid, held with meas_dly.
REQ-012 timeout  output  1  one-cycle pulse; no trigger within TIMEOUT cycles.
REQ-013 stray  output  1  one-cycle pulse; trigger rise seen while not armed.

Function
REQ-014 enable and trigger shall each be registered once, with a second register holding the prior sample; rise = sample 1 and prior 0.
REQ-015 Both inputs shall share identical detect latency, so detect latency cancels in the measurement.
REQ-016 States: IDLE, ARMED, shall be the only FSM states.
REQ-017 IDLE + enable rise -> ARMED, cnt <= 0, busy <= 1 on the same edge.
REQ-018 ARMED, no trigger rise, cnt+1 < TIMEOUT -> stay, cnt <= cnt+1.
REQ-019 ARMED + trigger rise -> meas_dly <= cnt+1, meas_valid pulse, meas_ok <= (cnt+1 == EXPECT_DLY), IDLE.
REQ-020 Trigger rise detected k cycles after enable rise detect shall yield meas_dly = k (k >= 1).
REQ-021 ARMED, no trigger rise, cnt+1 == TIMEOUT -> timeout pulse, meas_dly <= TIMEOUT, meas_ok <= 0, IDLE; meas_valid not asserted.
REQ-022 ARMED + enable rise without trigger rise -> restart: cnt <= 0, stay ARMED, no result output.
REQ-023 ARMED + simultaneous enable rise and trigger rise -> result reported per REQ-019, then ARMED with cnt <= 0 (re-arm) instead of IDLE.
REQ-024 ARMED + trigger rise on the same cycle cnt+1 == TIMEOUT -> trigger wins: meas_valid, no timeout.
REQ-025 IDLE + trigger rise -> stray pulse, no state change; IDLE + simultaneous enable and trigger rise -> stray pulse and arm.
REQ-026 Level-high trigger at arm time shall not complete a measurement; only a later rise counts.
REQ-027 cnt shall never wrap; TIMEOUT bounds it below 2^CNT_W.

Reset
REQ-028 rst_n low shall asynchronously force: state IDLE, cnt 0, input sample registers 0, busy 0, meas_valid 0, meas_dly 0, meas_ok 0, timeout 0, stray 0.
REQ-029 Reset asserted mid-measurement shall abort it with no meas_valid or timeout pulse.
REQ-030 First edge after rst_n release shall treat inputs already high as rises (prior samples are 0).

Structure
REQ-031 Shared package trig_meas_pkg shall hold the state encoding (IDLE, ARMED) and default CNT_W/TIMEOUT/EXPECT_DLY constants.
REQ-032 One sub-module, rise_detect (register, prior register, rise output, async active-low reset), instantiated once each for enable and trigger.

Verification
REQ-033 Enable pulse at t=5, trigger generator rising 5 clk edges later -> meas_valid once, meas_dly=5, meas_ok=1, busy low after.
REQ-034 Enable pulse, trigger rise 3 cycles later -> meas_dly=3, meas_ok=0; TIMEOUT=10, no trigger -> timeout pulse exactly 10 cycles after arm, meas_dly=10.
REQ-035 Enable pulse, second enable pulse 2 cycles later, trigger 5 cycles after second -> single meas_valid, meas_dly=5.
REQ-036 Trigger rise while idle -> stray pulse, busy stays 0; enable and trigger rising same cycle in ARMED -> meas_valid, busy stays 1, next result measured from that cycle.
REQ-037 rst_n low 2 cycles after arm -> all outputs 0 immediately, no meas_valid/timeout afterward; trigger rise at cnt+1==TIMEOUT -> meas_valid, no timeout.

Source files
------------

// File: rtl/trig_meas_pkg.sv
// trig_meas_pkg: shared FSM encoding and default sizing for the trigger delay meter.
package trig_meas_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_EXPECT_DLY = 5;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one sample register plus a prior-sample register; rise flags a 0->1 step.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic s, p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 1'b0;
            p <= 1'b0;
        end else begin
            s <= d;
            p <= s;
        end
    end

    assign rise = s & ~p;

endmodule

// File: rtl/trigger_delay_meter.sv
// trigger_delay_meter: counts clk cycles from an enable rise to the following trigger rise,
// flagging timeouts, stray triggers and whether the delay matched the nominal value.
module trigger_delay_meter
    import trig_meas_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int EXPECT_DLY = DEF_EXPECT_DLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             trigger,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_dly,
    output logic             meas_ok,
    output logic             timeout,
    output logic             stray
);

    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W:0] EXP    = (CNT_W+1)'(EXPECT_DLY);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   nxt;
    logic             en_rise, trig_rise;

    // Both inputs pass through identical detectors so their latency cancels.
    rise_detect u_en   (.clk(clk), .rst_n(rst_n), .d(enable),  .rise(en_rise));
    rise_detect u_trig (.clk(clk), .rst_n(rst_n), .d(trigger), .rise(trig_rise));

    assign nxt = {1'b0, cnt} + (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            meas_dly   <= '0;
            meas_ok    <= 1'b0;
            timeout    <= 1'b0;
            stray      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            stray      <= 1'b0;
            case (state)
                IDLE: begin
                    stray <= trig_rise;
                    if (en_rise) begin
                        state <= ARMED;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    // Trigger outranks both restart and timeout; a coincident enable re-arms.
                    if (trig_rise) begin
                        meas_valid <= 1'b1;
                        meas_dly   <= nxt[CNT_W-1:0];
                        meas_ok    <= (nxt == EXP);
                        cnt        <= '0;
                        state      <= en_rise ? ARMED : IDLE;
                        busy       <= en_rise;
                    end else if (en_rise) begin
                        cnt <= '0;
                    end else if (nxt == TO_LIM) begin
                        timeout  <= 1'b1;
                        meas_dly <= TO_LIM[CNT_W-1:0];
                        meas_ok  <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= nxt[CNT_W-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_delay_meter.sv
// tb_trigger_delay_meter: directed scenarios against trigger_delay_meter with TIMEOUT=10.
module tb_trigger_delay_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       trigger = 1'b0;
    logic       busy, meas_valid, meas_ok, timeout, stray;
    logic [7:0] meas_dly;

    int checks = 0;
    int errors = 0;
    int w_vf, w_vn, w_tf, w_tn, w_sf, w_sn, w_busy;

    trigger_delay_meter #(.CNT_W(8), .TIMEOUT(10), .EXPECT_DLY(5)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
        .busy(busy), .meas_valid(meas_valid), .meas_dly(meas_dly),
        .meas_ok(meas_ok), .timeout(timeout), .stray(stray)
    );

    always #5 clk = ~clk;

    // Advance n cycles, sampling 1ns after each rising edge; records first cycle and count of pulses.
    task automatic watch(input int n);
        w_vf = 0; w_vn = 0; w_tf = 0; w_tn = 0; w_sf = 0; w_sn = 0; w_busy = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (meas_valid) begin w_vn++; if (w_vf == 0) w_vf = i; end
            if (timeout)    begin w_tn++; if (w_tf == 0) w_tf = i; end
            if (stray)      begin w_sn++; if (w_sf == 0) w_sf = i; end
            if (busy) w_busy = 1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, meas_valid, meas_ok, timeout, stray} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, meas_valid, meas_ok, timeout, stray}); end
        checks++; if (meas_dly !== 8'd0) begin errors++; $display("FAIL reset_dly got %0d exp 0", meas_dly); end
        rst_n = 1'b1;
        watch(3);
        checks++; if (w_vn + w_tn + w_sn + w_busy !== 0) begin errors++; $display("FAIL reset_quiet got %0d events exp 0", w_vn + w_tn + w_sn + w_busy); end
    endtask

    task automatic test_nominal;
        enable = 1'b1;
        watch(1);
        enable = 1'b0;
        watch(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy got %b exp 1", busy); end
        watch(3);
        trigger = 1'b1;
        watch(6);
        checks++; if (w_vf !== 2 || w_vn !== 1) begin errors++; $display("FAIL nominal_valid got first %0d n %0d exp 2 1", w_vf, w_vn); end
        checks++; if (meas_dly !== 8'd5) begin errors++; $display("FAIL nominal_dly got %0d exp 5", meas_dly); end
        checks++; if (meas_ok !== 1'b1) begin errors++; $display("FAIL nominal_ok got %b exp 1", meas_ok); end
        checks++; if (busy !== 1'b0 || w_tn !== 0) begin errors++; $display("FAIL nominal_after got busy %b to %0d exp 0 0", busy, w_tn); end
        trigger = 1'b0;
        watch(2);
    endtask

    task automatic test_short;
        enable = 1'b1;
        watch(1);
        enable = 1'b0;
        watch(2);
        trigger = 1'b1;
        watch(5);
        checks++; if (w_vf !== 2 || w_vn !== 1) begin errors++; $display("FAIL short_valid got first %0d n %0d exp 2 1", w_vf, w_vn); end
        checks++; if (meas_dly !== 8'd3 || meas_ok !== 1'b0) begin errors++; $display("FAIL short_dly got %0d ok %b exp 3 0", meas_dly, meas_ok); end
        trigger = 1'b0;
        watch(2);
    endtask

    task automatic test_timeout;
        enable = 1'b1;
        watch(1);
        enable = 1'b0;
        watch(15);
        checks++; if (w_tf !== 11 || w_tn !== 1) begin errors++; $display("FAIL timeout_pulse got first %0d n %0d exp 11 1", w_tf, w_tn); end
        checks++; if (w_vn !== 0) begin errors++; $display("FAIL timeout_novalid got %0d exp 0", w_vn); end
        checks++; if (meas_dly !== 8'd10 || meas_ok !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_state got dly %0d ok %b busy %b exp 10 0 0", meas_dly, meas_ok, busy); end
    endtask

    task automatic test_restart;
        enable = 1'b1;
        watch(1);
        enable = 1'b0;
        watch(1);
        enable = 1'b1;
        watch(1);
        enable = 1'b0;
        watch(4);
        checks++; if (w_vn + w_tn !== 0) begin errors++; $display("FAIL restart_early got %0d events exp 0", w_vn + w_tn); end
        trigger = 1'b1;
        watch(5);
        checks++; if (w_vf !== 2 || w_vn !== 1) begin errors++; $display("FAIL restart_valid got first %0d n %0d exp 2 1", w_vf, w_vn); end
        checks++; if (meas_dly !== 8'd5 || meas_ok !== 1'b1) begin errors++; $display("FAIL restart_dly got %0d ok %b exp 5 1", meas_dly, meas_ok); end
        trigger = 1'b0;
        watch(2);
    endtask

    task automatic test_stray;
        trigger = 1'b1;
        watch(3);
        checks++; if (w_sf !== 2 || w_sn !== 1) begin errors++; $display("FAIL stray_pulse got first %0d n %0d exp 2 1", w_sf, w_sn); end
        checks++; if (w_busy !== 0) begin errors++; $display("FAIL stray_busy got %0d exp 0", w_busy); end
        trigger = 1'b0;
        watch(2);
    endtask

    task automatic test_back_to_back;
        enable = 1'b1;
        watch(1);
        enable = 1'b0;
        watch(2);
        enable = 1'b1;
        trigger = 1'b1;
        watch(1);
        enable = 1'b0;
        trigger = 1'b0;
        watch(1);
        checks++; if (meas_valid !== 1'b1 || meas_dly !== 8'd3) begin errors++; $display("FAIL b2b_first got valid %b dly %0d exp 1 3", meas_valid, meas_dly); end
        checks++; if (busy !== 1'b1 || w_sn !== 0) begin errors++; $display("FAIL b2b_rearm got busy %b stray %0d exp 1 0", busy, w_sn); end
        watch(2);
        trigger = 1'b1;
        watch(3);
        checks++; if (w_vf !== 2 || w_vn !== 1) begin errors++; $display("FAIL b2b_second got first %0d n %0d exp 2 1", w_vf, w_vn); end
        checks++; if (meas_dly !== 8'd4 || busy !== 1'b0) begin errors++; $display("FAIL b2b_dly got %0d busy %b exp 4 0", meas_dly, busy); end
        trigger = 1'b0;
        watch(2);
    endtask

    task automatic test_timeout_race;
        enable = 1'b1;
        watch(1);
        enable = 1'b0;
        watch(9);
        trigger = 1'b1;
        watch(4);
        checks++; if (w_vf !== 2 || w_vn !== 1) begin errors++; $display("FAIL race_valid got first %0d n %0d exp 2 1", w_vf, w_vn); end
        checks++; if (w_tn !== 0) begin errors++; $display("FAIL race_timeout got %0d exp 0", w_tn); end
        checks++; if (meas_dly !== 8'd10) begin errors++; $display("FAIL race_dly got %0d exp 10", meas_dly); end
        trigger = 1'b0;
        watch(2);
    endtask

    task automatic test_level_trigger;
        trigger = 1'b1;
        watch(3);
        enable = 1'b1;
        watch(1);
        enable = 1'b0;
        watch(15);
        checks++; if (w_vn !== 0 || w_tn !== 1) begin errors++; $display("FAIL level_trig got valid %0d to %0d exp 0 1", w_vn, w_tn); end
        trigger = 1'b0;
        watch(2);
    endtask

    task automatic test_reset_abort;
        enable = 1'b1;
        trigger = 1'b1;
        watch(1);
        enable = 1'b0;
        trigger = 1'b0;
        watch(1);
        checks++; if (w_sn !== 1 || busy !== 1'b1) begin errors++; $display("FAIL idle_both got stray %0d busy %b exp 1 1", w_sn, busy); end
        watch(2);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, meas_valid, meas_ok, timeout, stray} !== 5'b0 || meas_dly !== 8'd0) begin errors++; $display("FAIL abort_async got flags %b dly %0d exp 00000 0", {busy, meas_valid, meas_ok, timeout, stray}, meas_dly); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch(15);
        checks++; if (w_vn + w_tn !== 0 || w_busy !== 0) begin errors++; $display("FAIL abort_quiet got valid %0d to %0d busy %0d exp 0 0 0", w_vn, w_tn, w_busy); end
    endtask

    task automatic test_reset_release;
        rst_n = 1'b0;
        enable = 1'b1;
        watch(2);
        rst_n = 1'b1;
        watch(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_arm got busy %b exp 1", busy); end
        enable = 1'b0;
        watch(15);
        checks++; if (w_tn !== 1 || busy !== 1'b0) begin errors++; $display("FAIL release_timeout got to %0d busy %b exp 1 0", w_tn, busy); end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_short;
        test_timeout;
        test_restart;
        test_stray;
        test_back_to_back;
        test_timeout_race;
        test_level_trigger;
        test_reset_abort;
        test_reset_release;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
